// File: rtl/id_stage.sv
// RV32I decode / operand-issue stage for OP and OP-IMM instructions.
// Owns the register file and a per-register busy scoreboard.
module id_stage (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] instr,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] rs1_val,
  output logic [31:0] rs2_val,
  output logic [2:0]  funct3,
  output logic [6:0]  funct7,
  output logic [4:0]  rd_addr,
  output logic        illegal,
  input  logic        wb_valid,
  input  logic [4:0]  wb_addr,
  input  logic [31:0] wb_data
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] WAIT  = 2'd1;
  localparam logic [1:0] ISSUE = 2'd2;

  localparam logic [6:0] OPC_OP  = 7'b0110011;
  localparam logic [6:0] OPC_IMM = 7'b0010011;

  logic [1:0]  state_q, state_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] busy_q, busy_d;
  logic [31:0] rf_q [32];
  logic [31:0] rf_d [32];
  logic        illegal_q, illegal_d;
  logic [31:0] rs1_val_q, rs1_val_d;
  logic [31:0] rs2_val_q, rs2_val_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [6:0]  funct7_q, funct7_d;
  logic [4:0]  rd_addr_q, rd_addr_d;

  logic [6:0]  opc;
  logic [4:0]  rs1, rs2, rd;
  logic [2:0]  f3;
  logic        is_op, is_shift, in_legal;
  logic        wb_hit, haz1, haz2, hazard;
  logic [31:0] op1, reg2, op2;
  logic [6:0]  f7;

  assign opc      = instr_q[6:0];
  assign rd       = instr_q[11:7];
  assign f3       = instr_q[14:12];
  assign rs1      = instr_q[19:15];
  assign rs2      = instr_q[24:20];
  assign is_op    = (opc == OPC_OP);
  assign is_shift = !is_op && (f3 == 3'b001 || f3 == 3'b101);
  assign in_legal = (instr[6:0] == OPC_OP) || (instr[6:0] == OPC_IMM);
  assign wb_hit   = wb_valid && (wb_addr != 5'd0);

  // A same-cycle writeback both resolves the hazard and forwards its data.
  assign haz1   = busy_q[rs1] && !(wb_hit && wb_addr == rs1);
  assign haz2   = is_op && busy_q[rs2] && !(wb_hit && wb_addr == rs2);
  assign hazard = haz1 || haz2;

  always_comb begin
    op1 = rf_q[rs1];
    if (wb_hit && wb_addr == rs1) op1 = wb_data;
    if (rs1 == 5'd0) op1 = '0;
    reg2 = rf_q[rs2];
    if (wb_hit && wb_addr == rs2) reg2 = wb_data;
    if (rs2 == 5'd0) reg2 = '0;
  end

  always_comb begin
    op2 = {{20{instr_q[31]}}, instr_q[31:20]};
    f7  = 7'h00;
    unique case (1'b1)
      is_op: begin
        op2 = reg2;
        f7  = instr_q[31:25];
      end
      is_shift: begin
        op2 = {27'd0, instr_q[24:20]};
        if (f3 == 3'b101 && instr_q[30]) f7 = 7'h20;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    instr_d   = instr_q;
    busy_d    = busy_q;
    rf_d      = rf_q;
    illegal_d = 1'b0;
    rs1_val_d = rs1_val_q;
    rs2_val_d = rs2_val_q;
    funct3_d  = funct3_q;
    funct7_d  = funct7_q;
    rd_addr_d = rd_addr_q;
    if (wb_hit) begin
      rf_d[wb_addr]   = wb_data;
      busy_d[wb_addr] = 1'b0;
    end
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          if (in_legal) begin
            instr_d = instr;
            state_d = WAIT;
          end else begin
            illegal_d = 1'b1;
          end
        end
      end
      WAIT: begin
        if (!hazard) begin
          rs1_val_d = op1;
          rs2_val_d = op2;
          funct3_d  = f3;
          funct7_d  = f7;
          rd_addr_d = rd;
          // Set after the clear so a new claim on rd wins.
          if (rd != 5'd0) busy_d[rd] = 1'b1;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      instr_q   <= '0;
      busy_q    <= '0;
      illegal_q <= 1'b0;
      rs1_val_q <= '0;
      rs2_val_q <= '0;
      funct3_q  <= '0;
      funct7_q  <= '0;
      rd_addr_q <= '0;
      for (int i = 0; i < 32; i++) rf_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      instr_q   <= instr_d;
      busy_q    <= busy_d;
      illegal_q <= illegal_d;
      rs1_val_q <= rs1_val_d;
      rs2_val_q <= rs2_val_d;
      funct3_q  <= funct3_d;
      funct7_q  <= funct7_d;
      rd_addr_q <= rd_addr_d;
      rf_q      <= rf_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == ISSUE);
  assign illegal   = illegal_q;
  assign rs1_val   = rs1_val_q;
  assign rs2_val   = rs2_val_q;
  assign funct3    = funct3_q;
  assign funct7    = funct7_q;
  assign rd_addr   = rd_addr_q;

endmodule

// File: tb/tb_id_stage.sv
// Directed testbench for id_stage.
// Inputs change and outputs are sampled on the falling edge.
module tb_id_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] instr;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] rs1_val;
  logic [31:0] rs2_val;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [4:0]  rd_addr;
  logic        illegal;
  logic        wb_valid;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  id_stage dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .instr(instr),
    .out_valid(out_valid), .out_ready(out_ready),
    .rs1_val(rs1_val), .rs2_val(rs2_val),
    .funct3(funct3), .funct7(funct7), .rd_addr(rd_addr),
    .illegal(illegal),
    .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h want 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic do_wb(input logic [4:0] a, input logic [31:0] d);
    wb_valid = 1'b1;
    wb_addr  = a;
    wb_data  = d;
    @(negedge clk);
    wb_valid = 1'b0;
  endtask

  // Handshake one word; returns at the falling edge after acceptance.
  task automatic send(input logic [31:0] w);
    in_valid = 1'b1;
    instr    = w;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic consume();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic chk_out(input string tag,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [2:0] f3, input logic [6:0] f7,
                         input logic [4:0] rd);
    chk({tag, ".valid"}, {31'd0, out_valid}, 32'd1);
    chk({tag, ".rs1"}, rs1_val, a);
    chk({tag, ".rs2"}, rs2_val, b);
    chk({tag, ".f3"}, {29'd0, funct3}, {29'd0, f3});
    chk({tag, ".f7"}, {25'd0, funct7}, {25'd0, f7});
    chk({tag, ".rd"}, {27'd0, rd_addr}, {27'd0, rd});
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; instr = '0; out_ready = 1'b0;
    wb_valid = 1'b0; wb_addr = '0; wb_data = '0;
    repeat (2) @(negedge clk);
    chk("rst.valid", {31'd0, out_valid}, 32'd0);
    chk("rst.illegal", {31'd0, illegal}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst.in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst.rs1", rs1_val, 32'd0);

    do_wb(5'd5, 32'd20);
    do_wb(5'd6, 32'd30);

    // ADD x7,x5,x6
    send(32'h006283B3);
    chk("add.wait_valid", {31'd0, out_valid}, 32'd0);
    chk("add.wait_ready", {31'd0, in_ready}, 32'd0);
    @(negedge clk);
    chk_out("add", 32'd20, 32'd30, 3'd0, 7'h00, 5'd7);
    consume();

    // SUB x7,x5,x6
    send(32'h406283B3);
    @(negedge clk);
    chk_out("sub", 32'd20, 32'd30, 3'd0, 7'h20, 5'd7);
    consume();

    // ADDI x1,x0,-1
    send(32'hFFF00093);
    @(negedge clk);
    chk_out("addi", 32'd0, 32'hFFFF_FFFF, 3'd0, 7'h00, 5'd1);
    consume();

    // Retire x1 so SRAI sees no hazard
    do_wb(5'd1, 32'hFFFF_FFFF);
    send(32'h4030D113);
    @(negedge clk);
    chk_out("srai", 32'hFFFF_FFFF, 32'd3, 3'd5, 7'h20, 5'd2);
    consume();

    // ADD x8,x7,x7 stalls on busy x7
    send(32'h00738433);
    for (int i = 0; i < 4; i++) begin
      chk("raw.stall_valid", {31'd0, out_valid}, 32'd0);
      chk("raw.stall_ready", {31'd0, in_ready}, 32'd0);
      @(negedge clk);
    end
    do_wb(5'd7, 32'd50);
    chk_out("raw", 32'd50, 32'd50, 3'd0, 7'h00, 5'd8);

    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp.valid", {31'd0, out_valid}, 32'd1);
      chk("bp.ready", {31'd0, in_ready}, 32'd0);
      chk("bp.rs1", rs1_val, 32'd50);
      chk("bp.rd", {27'd0, rd_addr}, 32'd8);
    end
    consume();
    chk("bp.release_valid", {31'd0, out_valid}, 32'd0);
    chk("bp.release_ready", {31'd0, in_ready}, 32'd1);

    send(32'h0000_0000);
    chk("ill.pulse", {31'd0, illegal}, 32'd1);
    chk("ill.valid", {31'd0, out_valid}, 32'd0);
    chk("ill.ready", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    chk("ill.clear", {31'd0, illegal}, 32'd0);
    chk("ill.valid2", {31'd0, out_valid}, 32'd0);

    // Writes to x0 are ignored; ADD x3,x0,x0
    do_wb(5'd0, 32'd99);
    send(32'h000001B3);
    @(negedge clk);
    chk_out("x0", 32'd0, 32'd0, 3'd0, 7'h00, 5'd3);
    consume();

    // Leave x7 busy and reset while holding an issued instruction
    send(32'h006283B3);
    @(negedge clk);
    chk_out("pre_rst", 32'd20, 32'd30, 3'd0, 7'h00, 5'd7);
    rst_n = 1'b0;
    #1;
    chk("mrst.valid", {31'd0, out_valid}, 32'd0);
    chk("mrst.illegal", {31'd0, illegal}, 32'd0);
    chk("mrst.rs1", rs1_val, 32'd0);
    chk("mrst.rs2", rs2_val, 32'd0);
    chk("mrst.f3f7", {22'd0, funct3, funct7}, 32'd0);
    chk("mrst.rd", {27'd0, rd_addr}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("mrst.in_ready", {31'd0, in_ready}, 32'd1);

    // ADD x9,x7,x5: x7 no longer busy, x5 cleared
    send(32'h005384B3);
    @(negedge clk);
    chk_out("post_rst", 32'd0, 32'd0, 3'd0, 7'h00, 5'd9);
    consume();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
